// File: rtl/conv_pixel_writer_pkg.sv
// Shared definitions for the convolution pixel writer and VGA control:
// FSM encoding plus frame-memory word-address and lane helpers.
package conv_pixel_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        WRITE,
        RD_WAIT,
        MERGE
    } state_t;

    function automatic logic [15:0] word_addr(
        input logic [8:0] v,
        input logic [8:0] h
    );
        return {v, h[8:2]};
    endfunction

    function automatic logic [3:0] lane_sel(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [31:0] lane_put(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [7:0]  data
    );
        logic [31:0] w;
        w = word;
        w[{lane, 3'b000} +: 8] = data;
        return w;
    endfunction

endpackage

// File: rtl/conv_pixel_writer_merge.sv
// Byte-lane merge: masked lanes keep buffered pixels, others take memory data.
module pixel_lane_merge (
    input  logic [31:0] buf_data,
    input  logic [31:0] mem_rdata,
    input  logic [3:0]  mask,
    output logic [31:0] merged
);

    always_comb begin
        merged = mem_rdata;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) merged[8*k +: 8] = buf_data[8*k +: 8];
        end
    end

endmodule

// File: rtl/conv_pixel_writer.sv
// Packs filtered 8-bit pixels into 32-bit frame-memory words, writing full
// words directly and partial words via read-modify-write.
module conv_pixel_writer
    import conv_pixel_writer_pkg::*;
#(
    parameter int         READ_LATENCY = 2,
    parameter logic [8:0] H_LAST       = 9'd511,
    parameter logic [8:0] V_LAST       = 9'd479
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_data,
    input  logic [8:0]  pix_h,
    input  logic [8:0]  pix_v,
    input  logic        flush,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [15:0] LAST_ADDR = {V_LAST, H_LAST[8:2]};
    localparam logic [1:0]  LAST_LANE = H_LAST[1:0];
    localparam logic [1:0]  RL_M1     = 2'(READ_LATENCY - 1);

    state_t      state, state_nxt;
    logic [15:0] buf_addr, buf_addr_nxt;
    logic [31:0] buf_data, buf_data_nxt;
    logic [3:0]  buf_mask, buf_mask_nxt;
    logic [3:0]  pix_mask, pix_mask_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [7:0]  pend_data, pend_data_nxt;
    logic [8:0]  pend_h, pend_h_nxt;
    logic [8:0]  pend_v, pend_v_nxt;
    logic [1:0]  rd_cnt, rd_cnt_nxt;
    logic [31:0] merged;
    logic        accept;
    logic [15:0] pix_addr;
    logic [3:0]  pix_sel;

    assign pix_ready = (state == IDLE || state == ACCUM) && !pend_valid;
    assign busy      = (state != IDLE) || pend_valid;
    assign accept    = pix_valid && pix_ready;
    assign pix_addr  = word_addr(pix_v, pix_h);
    assign pix_sel   = lane_sel(pix_h[1:0]);

    pixel_lane_merge u_merge (
        .buf_data  (buf_data),
        .mem_rdata (mem_rdata),
        .mask      (buf_mask),
        .merged    (merged)
    );

    always_comb begin
        state_nxt      = state;
        buf_addr_nxt   = buf_addr;
        buf_data_nxt   = buf_data;
        buf_mask_nxt   = buf_mask;
        pix_mask_nxt   = pix_mask;
        pend_valid_nxt = pend_valid;
        pend_data_nxt  = pend_data;
        pend_h_nxt     = pend_h;
        pend_v_nxt     = pend_v;
        rd_cnt_nxt     = rd_cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    buf_addr_nxt = pix_addr;
                    buf_data_nxt = lane_put(buf_data, pix_h[1:0], pix_data);
                    buf_mask_nxt = pix_sel;
                    pix_mask_nxt = pix_sel;
                    state_nxt    = ACCUM;
                end
            end
            ACCUM: begin
                if (accept && pix_addr == buf_addr) begin
                    buf_data_nxt = lane_put(buf_data, pix_h[1:0], pix_data);
                    buf_mask_nxt = buf_mask | pix_sel;
                    pix_mask_nxt = pix_mask | pix_sel;
                    if ((buf_mask | pix_sel) == 4'hF) begin
                        state_nxt = WRITE;
                    end else if (flush) begin
                        state_nxt  = RD_WAIT;
                        rd_cnt_nxt = '0;
                    end
                end else if (accept) begin
                    // Different word: park the pixel and retire the buffer.
                    pend_valid_nxt = 1'b1;
                    pend_data_nxt  = pix_data;
                    pend_h_nxt     = pix_h;
                    pend_v_nxt     = pix_v;
                    if (buf_mask == 4'hF) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt  = RD_WAIT;
                        rd_cnt_nxt = '0;
                    end
                end else if (flush) begin
                    if (buf_mask == 4'hF) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt  = RD_WAIT;
                        rd_cnt_nxt = '0;
                    end
                end
            end
            RD_WAIT: begin
                if (rd_cnt == RL_M1) state_nxt = MERGE;
                else rd_cnt_nxt = rd_cnt + 2'd1;
            end
            MERGE: begin
                buf_data_nxt = merged;
                buf_mask_nxt = 4'hF;
                state_nxt    = WRITE;
            end
            WRITE: begin
                buf_mask_nxt = '0;
                pix_mask_nxt = '0;
                if (pend_valid) begin
                    buf_addr_nxt   = word_addr(pend_v, pend_h);
                    buf_data_nxt   = lane_put(buf_data, pend_h[1:0], pend_data);
                    buf_mask_nxt   = lane_sel(pend_h[1:0]);
                    pix_mask_nxt   = lane_sel(pend_h[1:0]);
                    pend_valid_nxt = 1'b0;
                    state_nxt      = ACCUM;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            buf_addr   <= '0;
            buf_data   <= '0;
            buf_mask   <= '0;
            pix_mask   <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            pend_h     <= '0;
            pend_v     <= '0;
            rd_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            buf_addr   <= buf_addr_nxt;
            buf_data   <= buf_data_nxt;
            buf_mask   <= buf_mask_nxt;
            pix_mask   <= pix_mask_nxt;
            pend_valid <= pend_valid_nxt;
            pend_data  <= pend_data_nxt;
            pend_h     <= pend_h_nxt;
            pend_v     <= pend_v_nxt;
            rd_cnt     <= rd_cnt_nxt;
        end
    end

    // Memory port is registered from next-state values so a word completed
    // at edge N is written in the very next cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            frame_done <= 1'b0;
        end else begin
            mem_we <= (state_nxt == WRITE);
            if (state_nxt inside {WRITE, RD_WAIT, MERGE}) mem_addr <= buf_addr_nxt;
            if (state_nxt == WRITE) mem_wdata <= buf_data_nxt;
            frame_done <= (state == WRITE) && (buf_addr == LAST_ADDR)
                          && pix_mask[LAST_LANE];
        end
    end

endmodule

// File: tb/tb_conv_pixel_writer.sv
// Directed bench for conv_pixel_writer: full words, read-modify-write,
// held pixels, flush corner cases, reset mid-word and a last-row raster.
module tb_conv_pixel_writer;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic [8:0]  pix_h;
    logic [8:0]  pix_v;
    logic        flush;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fd_cnt  = 0;
    int fd_cyc  = 0;

    logic [15:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];

    conv_pixel_writer #(
        .READ_LATENCY (RL),
        .H_LAST       (9'd511),
        .V_LAST       (9'd479)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_h      (pix_h),
        .pix_v      (pix_v),
        .flush      (flush),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [8:0] h, input logic [8:0] v,
                        input logic [7:0] d, output int acc);
        int t;
        pix_valid = 1'b1;
        pix_h     = h;
        pix_v     = v;
        pix_data  = d;
        t = 0;
        while (!pix_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!pix_ready) begin
            check("ready_timeout", 32'(pix_ready), 32'd1);
            pix_valid = 1'b0;
            acc = cyc;
            return;
        end
        acc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic pulse_flush(output int n);
        pix_valid = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n = cyc;
    endtask

    initial begin
        int acc;
        int n;
        reset_n   = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        pix_h     = '0;
        pix_v     = '0;
        flush     = 1'b0;
        mem_rdata = 32'hAABBCCDD;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(pix_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Full word, four lanes of row 0.
        clear_log();
        send(9'd0, 9'd0, 8'h11, acc);
        send(9'd1, 9'd0, 8'h22, acc);
        send(9'd2, 9'd0, 8'h33, acc);
        send(9'd3, 9'd0, 8'h44, acc);
        pix_valid = 1'b0;
        check("full_we", 32'(mem_we), 32'd1);
        check("full_ready_lo", 32'(pix_ready), 32'd0);
        check("full_addr", 32'(mem_addr), 32'h0000);
        check("full_wdata", mem_wdata, 32'h44332211);
        @(negedge clk);
        check("full_ready_hi", 32'(pix_ready), 32'd1);
        check("full_busy", 32'(busy), 32'd0);
        drain(4);
        check("full_nwr", wa.size(), 32'd1);
        if (wc.size() > 0) check("full_cyc", wc[0], acc);

        // Partial word closed by flush.
        clear_log();
        send(9'd4, 9'd2, 8'h01, acc);
        send(9'd5, 9'd2, 8'h02, acc);
        pulse_flush(n);
        check("rmw_rd_addr", 32'(mem_addr), 32'h0101);
        check("rmw_rd_we", 32'(mem_we), 32'd0);
        repeat (RL + 1) @(negedge clk);
        check("rmw_we", 32'(mem_we), 32'd1);
        check("rmw_addr", 32'(mem_addr), 32'h0101);
        check("rmw_wdata", mem_wdata, 32'hAABB0201);
        check("rmw_busy_wr", 32'(busy), 32'd1);
        @(negedge clk);
        check("rmw_busy_end", 32'(busy), 32'd0);
        drain(4);
        check("rmw_nwr", wa.size(), 32'd1);
        if (wc.size() > 0) check("rmw_cyc", wc[0], n + RL + 1);

        // Address change parks the second pixel.
        clear_log();
        send(9'd8, 9'd1, 8'h7F, acc);
        send(9'd20, 9'd1, 8'h80, acc);
        pix_valid = 1'b0;
        check("hold_ready", 32'(pix_ready), 32'd0);
        repeat (RL + 1) @(negedge clk);
        check("hold_we", 32'(mem_we), 32'd1);
        check("hold_addr", 32'(mem_addr), 32'h0082);
        check("hold_wdata", mem_wdata, 32'hAABBCC7F);
        drain(5);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_nwr", wa.size(), 32'd1);
        clear_log();
        pulse_flush(n);
        repeat (RL + 1) @(negedge clk);
        check("held_we", 32'(mem_we), 32'd1);
        check("held_addr", 32'(mem_addr), 32'h0085);
        check("held_wdata", mem_wdata, 32'hAABBCC80);
        @(negedge clk);
        check("held_busy_end", 32'(busy), 32'd0);

        // Flush while idle does nothing.
        drain(3);
        clear_log();
        pulse_flush(n);
        drain(8);
        check("idle_flush_nwr", wa.size(), 32'd0);
        check("idle_flush_busy", 32'(busy), 32'd0);

        // Reset with two lanes buffered discards them.
        send(9'd0, 9'd3, 8'hAA, acc);
        send(9'd1, 9'd3, 8'hBB, acc);
        pix_valid = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(pix_ready), 32'd1);
        drain(8);
        check("mid_rst_nwr", wa.size(), 32'd0);
        send(9'd0, 9'd3, 8'h5A, acc);
        pulse_flush(n);
        drain(8);
        check("fresh_nwr", wa.size(), 32'd1);
        if (wa.size() > 0) begin
            check("fresh_addr", 32'(wa[0]), 32'h0180);
            check("fresh_wdata", wd[0], 32'hAABBCC5A);
        end

        // Flush together with the completing pixel: only the full write.
        clear_log();
        send(9'd0, 9'd4, 8'h01, acc);
        send(9'd1, 9'd4, 8'h02, acc);
        send(9'd2, 9'd4, 8'h03, acc);
        flush = 1'b1;
        send(9'd3, 9'd4, 8'h04, acc);
        flush     = 1'b0;
        pix_valid = 1'b0;
        drain(8);
        check("fl_full_nwr", wa.size(), 32'd1);
        if (wa.size() > 0) begin
            check("fl_full_addr", 32'(wa[0]), 32'h0200);
            check("fl_full_wdata", wd[0], 32'h04030201);
            check("fl_full_cyc", wc[0], acc);
        end

        // Flush together with a non-completing pixel: RMW of updated word.
        clear_log();
        send(9'd4, 9'd4, 8'h10, acc);
        flush = 1'b1;
        send(9'd5, 9'd4, 8'h20, acc);
        flush     = 1'b0;
        pix_valid = 1'b0;
        drain(8);
        check("fl_part_nwr", wa.size(), 32'd1);
        if (wa.size() > 0) begin
            check("fl_part_addr", 32'(wa[0]), 32'h0201);
            check("fl_part_wdata", wd[0], 32'hAABB2010);
            check("fl_part_cyc", wc[0], acc + RL + 1);
        end

        // Last row of the frame, then the closing flush.
        check("fd_before", fd_cnt, 32'd0);
        clear_log();
        for (int h = 0; h < 512; h++) begin
            send(9'(h), 9'd479, 8'(h), acc);
        end
        pulse_flush(n);
        drain(8);
        check("raster_nwr", wa.size(), 32'd128);
        for (int k = 0; k < 128 && k < wa.size(); k++) begin
            check($sformatf("raster_addr_%0d", k), 32'(wa[k]), 32'(16'hEF80 + k));
            check($sformatf("raster_data_%0d", k), wd[k],
                  {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        end
        check("fd_count", fd_cnt, 32'd1);
        if (wc.size() > 0) check("fd_cyc", fd_cyc, wc[wc.size()-1] + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
